// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with MEM_LAT-cycle waits and hold.
// Optional macro MC_CTRL_PERF_EN adds free-running cycle and retired-instruction counters.
module mc_ctrl #(
  parameter int MEM_LAT = 1,
  localparam int CNT_W = $clog2(MEM_LAT + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        hold,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [1:0]  RegDst,
  output logic        ALUSrc,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUctr,
  output logic [1:0]  ExtOp,
  output logic [1:0]  NPCOp,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic        illegal,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ins_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_op;
  logic [5:0]       r_func;

  logic w_last, w_en;
  logic w_is_r, w_is_jr, w_is_jmp, w_legal;
  logic w_l_lw, w_l_sw, w_l_beq, w_l_mem;
  logic w_pcw, w_irw, w_rw, w_mw, w_done, w_ill;
  logic [1:0] w_regdst, w_memtoreg, w_aluctr, w_extop, w_npcop;
  logic w_alusrc;

  assign w_last = (r_cnt == CNT_W'(MEM_LAT - 1));
  // Strobes are suppressed both while held and while reset is asserted.
  assign w_en   = reset & ~hold;

  // DECODE classifies the freshly loaded instruction straight from the IR.
  assign w_is_r   = (op == OP_RTYPE) && ((func == FN_ADDU) || (func == FN_SUBU));
  assign w_is_jr  = (op == OP_RTYPE) && (func == FN_JR);
  assign w_is_jmp = (op == OP_J) || (op == OP_JAL);
  assign w_legal  = w_is_r || w_is_jr || w_is_jmp || (op == OP_ORI) || (op == OP_LW) ||
                    (op == OP_SW) || (op == OP_BEQ) || (op == OP_LUI);

  assign w_l_lw  = (r_op == OP_LW);
  assign w_l_sw  = (r_op == OP_SW);
  assign w_l_beq = (r_op == OP_BEQ);
  assign w_l_mem = w_l_lw || w_l_sw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_op    <= '0;
      r_func  <= '0;
    end else if (!hold) begin
      case (r_state)
        S_FETCH: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_DECODE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          r_op    <= op;
          r_func  <= func;
          r_state <= (w_is_jmp || w_is_jr || !w_legal) ? S_FETCH : S_EXEC;
        end
        S_EXEC: begin
          if (w_l_beq)      r_state <= S_FETCH;
          else if (w_l_mem) r_state <= S_MEM;
          else              r_state <= S_WB;
        end
        S_MEM: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= w_l_lw ? S_WB : S_FETCH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_pcw      = 1'b0;
    w_irw      = 1'b0;
    w_rw       = 1'b0;
    w_mw       = 1'b0;
    w_done     = 1'b0;
    w_ill      = 1'b0;
    w_regdst   = 2'b00;
    w_memtoreg = 2'b00;
    w_alusrc   = 1'b0;
    w_aluctr   = 2'b00;
    w_extop    = 2'b00;
    w_npcop    = 2'b00;
    // ALU/EXT controls stay valid from EXEC through MEM and WB so the address/result is stable.
    if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
      case (r_op)
        OP_RTYPE: w_aluctr = (r_func == FN_SUBU) ? 2'b01 : 2'b00;
        OP_ORI: begin
          w_alusrc = 1'b1;
          w_aluctr = 2'b10;
        end
        OP_LUI: begin
          w_alusrc = 1'b1;
          w_aluctr = 2'b10;
          w_extop  = 2'b10;
        end
        OP_LW, OP_SW: begin
          w_alusrc = 1'b1;
          w_extop  = 2'b01;
        end
        OP_BEQ: begin
          w_aluctr = 2'b01;
          w_extop  = 2'b01;
        end
        default: ;
      endcase
    end
    case (r_state)
      S_FETCH: begin
        w_irw = w_last;
        w_pcw = w_last;
      end
      S_DECODE: begin
        if (w_is_jmp) begin
          w_pcw   = 1'b1;
          w_npcop = 2'b10;
          w_done  = 1'b1;
          if (op == OP_JAL) begin
            w_rw       = 1'b1;
            w_regdst   = 2'b10;
            w_memtoreg = 2'b10;
          end
        end else if (w_is_jr) begin
          w_pcw   = 1'b1;
          w_npcop = 2'b11;
          w_done  = 1'b1;
        end else if (!w_legal) begin
          w_ill  = 1'b1;
          w_done = 1'b1;
        end
      end
      S_EXEC: begin
        if (w_l_beq) begin
          w_npcop = 2'b01;
          w_pcw   = zero;
          w_done  = 1'b1;
        end
      end
      S_MEM: begin
        w_mw   = w_l_sw && w_last;
        w_done = w_l_sw && w_last;
      end
      S_WB: begin
        w_rw       = 1'b1;
        w_done     = 1'b1;
        w_regdst   = (r_op == OP_RTYPE) ? 2'b01 : 2'b00;
        w_memtoreg = w_l_lw ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

  assign PCWrite    = w_pcw  & w_en;
  assign IRWrite    = w_irw  & w_en;
  assign RegWrite   = w_rw   & w_en;
  assign MemWrite   = w_mw   & w_en;
  assign instr_done = w_done & w_en;
  assign illegal    = w_ill  & w_en;
  assign RegDst     = w_regdst;
  assign ALUSrc     = w_alusrc;
  assign MemtoReg   = w_memtoreg;
  assign ALUctr     = w_aluctr;
  assign ExtOp      = w_extop;
  assign NPCOp      = w_npcop;
  assign state      = r_state;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_ins_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cyc_cnt <= '0;
      r_ins_cnt <= '0;
    end else if (!hold) begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (w_done) r_ins_cnt <= r_ins_cnt + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
  assign ins_cnt = r_ins_cnt;
`else
  assign cyc_cnt = '0;
  assign ins_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: scoreboard of per-instruction expected traces at MEM_LAT=1 and 3.
module tb_mc_ctrl;

  typedef struct packed {
    logic       pcw;
    logic       irw;
    logic       rw;
    logic       mw;
    logic [1:0] rd;
    logic       als;
    logic [1:0] m2r;
    logic [1:0] alu;
    logic [1:0] ext;
    logic [1:0] npc;
    logic [2:0] st;
    logic       done;
    logic       ill;
  } outs_t;

  typedef struct packed {
    logic [7:0] cycles;
    logic [7:0] ir_cyc;
    logic [3:0] ir_cnt;
    logic [3:0] pc_cnt;
    logic [3:0] rw_cnt;
    logic [3:0] mw_cnt;
    logic [7:0] mw_cyc;
    logic [3:0] ill_cnt;
    logic [1:0] rd;
    logic [1:0] m2r;
    logic [1:0] npc;
    logic [4:0] alu;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       zero = 1'b0;
  logic       hold = 1'b0;
  logic [5:0] op = 6'd0;
  logic [5:0] func = 6'd0;
  logic       sel3 = 1'b0;

  wire [19:0] o1, o3;
  wire [31:0] cyc1, ins1, cyc3, ins3;
  outs_t      ob;

  int checks = 0;
  int failures = 0;
  rec_t sb[$];

  always #5 clk = ~clk;

  mc_ctrl #(.MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .hold(hold),
    .PCWrite(o1[19]), .IRWrite(o1[18]), .RegWrite(o1[17]), .MemWrite(o1[16]),
    .RegDst(o1[15:14]), .ALUSrc(o1[13]), .MemtoReg(o1[12:11]), .ALUctr(o1[10:9]),
    .ExtOp(o1[8:7]), .NPCOp(o1[6:5]), .state(o1[4:2]), .instr_done(o1[1]),
    .illegal(o1[0]), .cyc_cnt(cyc1), .ins_cnt(ins1)
  );

  mc_ctrl #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .hold(hold),
    .PCWrite(o3[19]), .IRWrite(o3[18]), .RegWrite(o3[17]), .MemWrite(o3[16]),
    .RegDst(o3[15:14]), .ALUSrc(o3[13]), .MemtoReg(o3[12:11]), .ALUctr(o3[10:9]),
    .ExtOp(o3[8:7]), .NPCOp(o3[6:5]), .state(o3[4:2]), .instr_done(o3[1]),
    .illegal(o3[0]), .cyc_cnt(cyc3), .ins_cnt(ins3)
  );

  assign ob = sel3 ? o3 : o1;

  // Expected per-instruction trace derived from the latency table and control encodings.
  function automatic rec_t model(input logic [5:0] o, input logic [5:0] f, input logic z,
                                 input int lat, input int hl);
    rec_t r;
    int   cyc;
    r = '0;
    r.ir_cyc = 8'(lat);
    r.ir_cnt = 4'd1;
    r.pc_cnt = 4'd1;
    cyc = lat + 1;
    case (o)
      6'b000000: begin
        if (f == 6'b100001 || f == 6'b100011) begin
          cyc = lat + 3;
          r.rw_cnt = 4'd1;
          r.rd = 2'b01;
          r.alu = {1'b0, (f == 6'b100011) ? 2'b01 : 2'b00, 2'b00};
        end else if (f == 6'b001000) begin
          r.pc_cnt = 4'd2;
          r.npc = 2'b11;
        end else begin
          r.ill_cnt = 4'd1;
        end
      end
      6'b001101: begin cyc = lat + 3; r.rw_cnt = 4'd1; r.alu = {1'b1, 2'b10, 2'b00}; end
      6'b001111: begin cyc = lat + 3; r.rw_cnt = 4'd1; r.alu = {1'b1, 2'b10, 2'b10}; end
      6'b100011: begin
        cyc = 2 * lat + 3;
        r.rw_cnt = 4'd1;
        r.m2r = 2'b01;
        r.alu = {1'b1, 2'b00, 2'b01};
      end
      6'b101011: begin
        cyc = 2 * lat + 2;
        r.mw_cnt = 4'd1;
        r.mw_cyc = 8'(2 * lat + 2);
        r.alu = {1'b1, 2'b00, 2'b01};
      end
      6'b000100: begin
        cyc = lat + 2;
        r.pc_cnt = z ? 4'd2 : 4'd1;
        r.npc = z ? 2'b01 : 2'b00;
        r.alu = {1'b0, 2'b01, 2'b01};
      end
      6'b000010: begin r.pc_cnt = 4'd2; r.npc = 2'b10; end
      6'b000011: begin
        r.pc_cnt = 4'd2;
        r.npc = 2'b10;
        r.rw_cnt = 4'd1;
        r.rd = 2'b10;
        r.m2r = 2'b10;
      end
      default: r.ill_cnt = 4'd1;
    endcase
    r.cycles = 8'(cyc + hl);
    return r;
  endfunction

  // Push the expected trace, then drive one instruction and record what the selected DUT did.
  task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input int hold_at, input int hold_len, output rec_t r, output int hb);
    int   cyc;
    logic fin;
    logic [2:0] st0;
    sb.push_back(model(o, f, z, sel3 ? 3 : 1, hold_len));
    op = o;
    func = f;
    zero = z;
    r = '0;
    hb = 0;
    cyc = 0;
    fin = 1'b0;
    st0 = 3'd0;
    while (!fin && cyc < 200) begin
      cyc++;
      hold = (hold_len > 0) && (cyc >= hold_at) && (cyc < hold_at + hold_len);
      #1;
      if (hold) begin
        if (cyc == hold_at) st0 = ob.st;
        else if (ob.st !== st0) hb++;
        if (ob.pcw | ob.irw | ob.rw | ob.mw | ob.done | ob.ill) hb++;
      end else begin
        if (ob.irw) begin
          r.ir_cnt = r.ir_cnt + 4'd1;
          if (r.ir_cyc == 8'd0) r.ir_cyc = 8'(cyc);
        end
        if (ob.pcw) begin
          r.pc_cnt = r.pc_cnt + 4'd1;
          r.npc = ob.npc;
        end
        if (ob.rw) begin
          r.rw_cnt = r.rw_cnt + 4'd1;
          r.rd = ob.rd;
          r.m2r = ob.m2r;
        end
        if (ob.mw) begin
          r.mw_cnt = r.mw_cnt + 4'd1;
          r.mw_cyc = 8'(cyc);
        end
        if (ob.ill) r.ill_cnt = r.ill_cnt + 4'd1;
        if (ob.done) begin
          fin = 1'b1;
          r.cycles = 8'(cyc);
          if (ob.st >= 3'd2) r.alu = {ob.als, ob.alu, (o != 6'd0) ? ob.ext : 2'b00};
        end
      end
      @(negedge clk);
    end
    hold = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (o1 !== 20'h0) begin failures++; $display("FAIL reset_outs_lat1 got=%h want=00000", o1); end
    checks++;
    if (o3 !== 20'h0) begin failures++; $display("FAIL reset_outs_lat3 got=%h want=00000", o3); end
    checks++;
    if ((cyc1 | ins1 | cyc3 | ins3) !== 32'h0) begin
      failures++;
      $display("FAIL reset_perf got cyc=%0d ins=%0d want 0/0", cyc1, ins1);
    end
    $display("txn reset outs=%h", o1);
    reset = 1'b1;
  endtask

  task automatic test_alu_ops();
    logic [11:0] tbl[4];
    rec_t obs, e;
    int hb;
    tbl = '{ {6'b000000, 6'b100001}, {6'b001101, 6'b000000},
             {6'b000000, 6'b100011}, {6'b001111, 6'b000000} };
    for (int i = 0; i < 4; i++) begin
      issue(tbl[i][11:6], tbl[i][5:0], 1'b0, 0, 0, obs, hb);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL alu_op op=%b func=%b got=%h want=%h", tbl[i][11:6], tbl[i][5:0], obs, e);
      end
      $display("txn alu op=%b func=%b cycles=%0d", tbl[i][11:6], tbl[i][5:0], obs.cycles);
    end
  endtask

  task automatic test_branch();
    rec_t obs, e;
    int hb;
    for (int i = 0; i < 2; i++) begin
      issue(6'b000100, 6'd0, (i == 0), 0, 0, obs, hb);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL beq zero=%0d got=%h want=%h", (i == 0), obs, e);
      end
      $display("txn beq zero=%0d cycles=%0d pcw=%0d", (i == 0), obs.cycles, obs.pc_cnt);
    end
  endtask

  task automatic test_jumps();
    logic [11:0] tbl[5];
    rec_t obs, e;
    int hb;
    tbl = '{ {6'b000011, 6'd0}, {6'b000010, 6'd0}, {6'b000000, 6'b001000},
             {6'b111111, 6'd0}, {6'b000000, 6'b000000} };
    for (int i = 0; i < 5; i++) begin
      issue(tbl[i][11:6], tbl[i][5:0], 1'b0, 0, 0, obs, hb);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL jump op=%b func=%b got=%h want=%h", tbl[i][11:6], tbl[i][5:0], obs, e);
      end
      $display("txn jump op=%b func=%b cycles=%0d ill=%0d", tbl[i][11:6], tbl[i][5:0], obs.cycles, obs.ill_cnt);
    end
  endtask

  task automatic test_mem();
    logic [5:0] ops[2];
    rec_t obs, e;
    int hb;
    ops = '{6'b100011, 6'b101011};
    for (int i = 0; i < 2; i++) begin
      issue(ops[i], 6'd0, 1'b0, 0, 0, obs, hb);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL mem op=%b got=%h want=%h", ops[i], obs, e);
      end
      $display("txn mem op=%b cycles=%0d mw_cyc=%0d", ops[i], obs.cycles, obs.mw_cyc);
    end
  endtask

  task automatic test_hold();
    rec_t obs, e;
    int hb;
    issue(6'b100011, 6'd0, 1'b0, 7, 5, obs, hb);
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL hold_lw got=%h want=%h", obs, e); end
    checks++;
    if (hb !== 0) begin failures++; $display("FAIL hold_frozen violations=%0d want 0", hb); end
    $display("txn hold lw cycles=%0d violations=%0d", obs.cycles, hb);
  endtask

  task automatic test_reset_mid();
    op = 6'b000000;
    func = 6'b100001;
    for (int c = 1; c <= 3; c++) begin
      #1;
      if (c < 3) @(negedge clk);
    end
    checks++;
    if (ob.st !== 3'd2) begin failures++; $display("FAIL mid_state_exec got=%0d want=2", ob.st); end
    reset = 1'b0;
    #1;
    checks++;
    if (o1 !== 20'h0 || cyc1 !== 32'h0 || ins1 !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset_async got=%h cyc=%0d ins=%0d want=00000 0 0", o1, cyc1, ins1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (o1 !== 20'h0) begin failures++; $display("FAIL mid_reset_held got=%h want=00000", o1); end
    $display("txn reset_mid outs=%h", o1);
    reset = 1'b1;
  endtask

  task automatic test_perf();
    rec_t obs, e;
    int hb;
    int exp_cyc, exp_ins;
    for (int i = 0; i < 10; i++) begin
      issue(6'b000000, 6'b100001, 1'b0, 0, 0, obs, hb);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL perf_addu%0d got=%h want=%h", i, obs, e); end
    end
`ifdef MC_CTRL_PERF_EN
    exp_cyc = 40;
    exp_ins = 10;
`else
    exp_cyc = 0;
    exp_ins = 0;
`endif
    #1;
    checks++;
    if (cyc1 !== 32'(exp_cyc)) begin failures++; $display("FAIL perf_cyc got=%0d want=%0d", cyc1, exp_cyc); end
    checks++;
    if (ins1 !== 32'(exp_ins)) begin failures++; $display("FAIL perf_ins got=%0d want=%0d", ins1, exp_ins); end
    $display("txn perf cyc=%0d ins=%0d", cyc1, ins1);
  endtask

  initial begin
    test_reset();
    sel3 = 1'b0;
    test_alu_ops();
    test_branch();
    test_jumps();
    sel3 = 1'b1;
    do_reset();
    test_mem();
    test_branch();
    test_hold();
    sel3 = 1'b0;
    do_reset();
    test_reset_mid();
    test_perf();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
